mem_prog_ctrl: RTL and testbench
================================

# mem_prog_ctrl

Host-side programming and run controller that drives the pipeline's I-mem/D-mem programming ports and its run/step/pc-reset controls. Accepts one command at a time over a valid/ready command port from the software register stage, sequences the required strobes with correct BRAM read latency, and returns a single-cycle response with status and read data. It is the initiator for the pipeline's programming and control inputs.

## Interface
- CNT_W, 32, width of the advance counter
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle and able to accept; high only in IDLE
- cmd_op  in  3  0 NOP, 1 IMEM_WR, 2 DMEM_WR, 3 DMEM_RD, 4 RUN, 5 HALT, 6 STEP, 7 PC_RESET
- cmd_addr  in  9  I-mem word address; D-mem uses [7:0], [8] must be 0
- cmd_wdata  in  64  write data; I-mem uses [31:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  command rejected; valid with resp_valid
- resp_data  out  64  D-mem read data for DMEM_RD, else 0; valid with resp_valid
- imem_prog_we  out  1  I-mem write strobe
- imem_prog_addr  out  9  I-mem address
- imem_prog_wdata  out  32  I-mem write data
- dmem_prog_en  out  1  D-mem port B enable
- dmem_prog_we  out  1  D-mem port B write enable
- dmem_prog_addr  out  8  D-mem address
- dmem_prog_wdata  out  64  D-mem write data
- dmem_prog_rdata  in  64  D-mem port B read data, one-cycle registered latency
- run  out  1  level; pipeline free-runs while high
- step  out  1  single-step level; high exactly one cycle per STEP
- pc_reset_pulse  out  1  one-cycle software PC reset
- adv_count  out  CNT_W  pipeline advances since reset/PC_RESET

## Operation
- States: IDLE, IMEM_WR, DMEM_WR, RD_EN, RD_CAP, STEP_HI, STEP_LO, PCRST, RESP.
- Accept on cmd_valid & cmd_ready; op, addr and wdata are registered at acceptance.
- IDLE → IMEM_WR (op 1), DMEM_WR (op 2), RD_EN (op 3), STEP_HI (op 6), PCRST (op 7). NOP, RUN, HALT and rejected commands → RESP.
- IMEM_WR: imem_prog_we=1 with the registered address and wdata[31:0] → RESP.
- DMEM_WR: dmem_prog_en=1, dmem_prog_we=1, addr[7:0], wdata → RESP.
- RD_EN: dmem_prog_en=1, we=0 → RD_CAP. RD_CAP: register dmem_prog_rdata into resp_data → RESP.
- STEP_HI: step=1 → STEP_LO: step=0 → RESP. This guarantees a rising edge per STEP.
- PCRST: pc_reset_pulse=1, run cleared to 0, adv_count cleared → RESP.
- RUN sets run=1; HALT clears run=0. Both go directly to RESP.
- RESP: resp_valid=1 for one cycle → IDLE.
- Rejection (resp_err=1, no strobes issued, run unchanged):
  - IMEM_WR, DMEM_WR, DMEM_RD or STEP while run=1.
  - DMEM op with cmd_addr[8]=1.
- PC_RESET, HALT, RUN and NOP are never rejected. RUN while already running is ok with no change.
- adv_count: +1 each cycle run=1 and +1 in each STEP_HI cycle. Wraps modulo 2^CNT_W. Clear has priority over increment.
- imem_prog_we and run are never both 1.

## Timing
- Acceptance edge defines cycle 0. Outputs below are registered.
- Writes: strobe in cycle 1, resp_valid in cycle 2, cmd_ready=1 in cycle 3.
- DMEM_RD: en in cycle 1, rdata sampled at end of cycle 2, resp_valid with data in cycle 3.
- STEP: step=1 in cycle 1, 0 in cycle 2, resp in cycle 3. The earliest next step high is cycle 5.
- PC_RESET: pulse and run=0 in cycle 1, resp in cycle 2.
- NOP, RUN, HALT and rejects: resp_valid in cycle 1. run changes in cycle 1.
- Strobe address/data are stable for the whole strobe cycle. All strobes are 0 outside their state.
- Reset values: all outputs 0 (cmd_ready 0 during reset), state IDLE. Reset mid-command aborts it with no resp_valid. cmd_ready=1 in the first cycle after reset deasserts.

## Test plan
- IMEM_WR addr 0x1A5, wdata 0xC0A00000 → imem_prog_we=1 in cycle 1 with addr 0x1A5 and data 0xC0A00000; resp_valid in cycle 2 with err=0.
- DMEM_WR addr 0x10, data 0x0123456789ABCDEF, then DMEM_RD addr 0x10 → resp_data 0x0123456789ABCDEF in cycle 3 of the read.
- STEP ×3 back-to-back with cmd_valid held → three single-cycle step highs separated by low cycles; adv_count=3.
- RUN, then IMEM_WR → resp_err=1 and no imem_prog_we. HALT after 10 cycles → adv_count=10; run=0.
- DMEM_RD addr 0x100 → resp_err=1 in cycle 1 and dmem_prog_en stays 0. PC_RESET while running → pc_reset_pulse for one cycle, run=0, adv_count=0.
- Reset asserted in RD_CAP → no resp_valid; all outputs 0. First command after reset is accepted normally.

Source files
------------

// File: rtl/mem_prog_ctrl_if.sv
// mem_prog_ctrl_if
// Command/response bus between the software register stage (master) and the
// memory programming / run controller (slave).
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : controller idle and able to accept (slave -> master)
//   cmd_op     : 0 NOP, 1 IMEM_WR, 2 DMEM_WR, 3 DMEM_RD, 4 RUN, 5 HALT, 6 STEP, 7 PC_RESET
//   cmd_addr   : I-mem word address; D-mem uses [7:0] and [8] must be 0
//   cmd_wdata  : write data; I-mem uses [31:0]
//   resp_valid : one-cycle completion pulse (slave -> master)
//   resp_err   : command rejected, qualified by resp_valid
//   resp_data  : D-mem read data for DMEM_RD, otherwise 0
interface mem_prog_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, resp_valid, resp_err, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, resp_valid, resp_err, resp_data
    );
endinterface

// File: rtl/mem_prog_ctrl.sv
// mem_prog_ctrl
// Host-side programming and run controller. Takes one command at a time from
// the host bus, sequences the I-mem / D-mem programming strobes (honouring the
// one-cycle registered D-mem read latency), drives the pipeline run / step /
// pc-reset controls, and answers every accepted command with a single-cycle
// response carrying status and read data.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   host               : command/response bus (slave side)
//   imem_prog_*        : I-mem programming port (write only)
//   dmem_prog_*        : D-mem port B (enable, write enable, address, data, rdata)
//   run                : level, pipeline free-runs while high
//   step               : high for exactly one cycle per STEP command
//   pc_reset_pulse     : one-cycle software PC reset
//   adv_count          : pipeline advances since reset or PC_RESET
module mem_prog_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_prog_ctrl_if.slave     host,
    output logic               imem_prog_we,
    output logic [8:0]         imem_prog_addr,
    output logic [31:0]        imem_prog_wdata,
    output logic               dmem_prog_en,
    output logic               dmem_prog_we,
    output logic [7:0]         dmem_prog_addr,
    output logic [63:0]        dmem_prog_wdata,
    input  logic [63:0]        dmem_prog_rdata,
    output logic               run,
    output logic               step,
    output logic               pc_reset_pulse,
    output logic [CNT_W-1:0]   adv_count
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_IMEM_WR = 4'd1,
        ST_DMEM_WR = 4'd2,
        ST_RD_EN   = 4'd3,
        ST_RD_CAP  = 4'd4,
        ST_STEP_HI = 4'd5,
        ST_STEP_LO = 4'd6,
        ST_PCRST   = 4'd7,
        ST_RESP    = 4'd8
    } state_t;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_IMEM_WR  = 3'd1;
    localparam logic [2:0] OP_DMEM_WR  = 3'd2;
    localparam logic [2:0] OP_DMEM_RD  = 3'd3;
    localparam logic [2:0] OP_RUN      = 3'd4;
    localparam logic [2:0] OP_HALT     = 3'd5;
    localparam logic [2:0] OP_STEP     = 3'd6;
    localparam logic [2:0] OP_PC_RESET = 3'd7;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [8:0]         addr_r;
    logic [63:0]        wdata_r;
    logic               imem_we_r,    imem_we_nxt_s;
    logic               dmem_en_r,    dmem_en_nxt_s;
    logic               dmem_we_r,    dmem_we_nxt_s;
    logic               run_r,        run_nxt_s;
    logic               step_r,       step_nxt_s;
    logic               pcrst_r,      pcrst_nxt_s;
    logic               resp_valid_r, resp_valid_nxt_s;
    logic               resp_err_r,   resp_err_nxt_s;
    logic [63:0]        resp_data_r,  resp_data_nxt_s;
    logic [CNT_W-1:0]   adv_count_r;
    logic               cnt_clr_s;
    logic               cnt_inc_s;
    logic               cmd_ready_s;
    logic               accept_s;
    logic               reject_s;

    // Ready is gated by reset so the host never sees ready while reset is held
    // and sees it immediately once reset drops with the FSM parked in IDLE.
    assign cmd_ready_s = (state_r == ST_IDLE) && !reset;
    assign accept_s    = host.cmd_valid && cmd_ready_s;

    // Rejection check on the live command; a rejected command issues no strobe.
    always_comb begin
        reject_s = 1'b0;
        case (host.cmd_op)
            OP_IMEM_WR: reject_s = run_r;
            OP_DMEM_WR: reject_s = run_r || host.cmd_addr[8];
            OP_DMEM_RD: reject_s = run_r || host.cmd_addr[8];
            OP_STEP:    reject_s = run_r;
            default:    reject_s = 1'b0;
        endcase
    end

    // Next-state and next-output decode; outputs are registered one edge later
    // so each strobe is high exactly while the FSM sits in its state.
    always_comb begin
        state_nxt_s      = state_r;
        imem_we_nxt_s    = 1'b0;
        dmem_en_nxt_s    = 1'b0;
        dmem_we_nxt_s    = 1'b0;
        run_nxt_s        = run_r;
        step_nxt_s       = 1'b0;
        pcrst_nxt_s      = 1'b0;
        resp_valid_nxt_s = 1'b0;
        resp_err_nxt_s   = 1'b0;
        resp_data_nxt_s  = 64'd0;
        cnt_clr_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (reject_s) begin
                        state_nxt_s      = ST_RESP;
                        resp_valid_nxt_s = 1'b1;
                        resp_err_nxt_s   = 1'b1;
                    end else begin
                        case (host.cmd_op)
                            OP_IMEM_WR: begin
                                state_nxt_s   = ST_IMEM_WR;
                                imem_we_nxt_s = 1'b1;
                            end
                            OP_DMEM_WR: begin
                                state_nxt_s   = ST_DMEM_WR;
                                dmem_en_nxt_s = 1'b1;
                                dmem_we_nxt_s = 1'b1;
                            end
                            OP_DMEM_RD: begin
                                state_nxt_s   = ST_RD_EN;
                                dmem_en_nxt_s = 1'b1;
                            end
                            OP_STEP: begin
                                state_nxt_s = ST_STEP_HI;
                                step_nxt_s  = 1'b1;
                            end
                            OP_PC_RESET: begin
                                state_nxt_s = ST_PCRST;
                                pcrst_nxt_s = 1'b1;
                                run_nxt_s   = 1'b0;
                                cnt_clr_s   = 1'b1;
                            end
                            OP_RUN: begin
                                state_nxt_s      = ST_RESP;
                                run_nxt_s        = 1'b1;
                                resp_valid_nxt_s = 1'b1;
                            end
                            OP_HALT: begin
                                state_nxt_s      = ST_RESP;
                                run_nxt_s        = 1'b0;
                                resp_valid_nxt_s = 1'b1;
                            end
                            default: begin
                                state_nxt_s      = ST_RESP;
                                resp_valid_nxt_s = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IMEM_WR, ST_DMEM_WR, ST_PCRST, ST_STEP_LO: begin
                state_nxt_s      = ST_RESP;
                resp_valid_nxt_s = 1'b1;
            end
            ST_RD_EN: begin
                state_nxt_s = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                // Port B data for the RD_EN address is valid in this cycle.
                state_nxt_s      = ST_RESP;
                resp_valid_nxt_s = 1'b1;
                resp_data_nxt_s  = dmem_prog_rdata;
            end
            ST_STEP_HI: begin
                state_nxt_s = ST_STEP_LO;
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One advance per running cycle or per step-high cycle; never both at once
    // because STEP is rejected while running.
    assign cnt_inc_s = run_r || step_r;

    // State, output and command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= 9'd0;
            wdata_r      <= 64'd0;
            imem_we_r    <= 1'b0;
            dmem_en_r    <= 1'b0;
            dmem_we_r    <= 1'b0;
            run_r        <= 1'b0;
            step_r       <= 1'b0;
            pcrst_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_data_r  <= 64'd0;
            adv_count_r  <= '0;
        end else begin
            state_r      <= state_nxt_s;
            imem_we_r    <= imem_we_nxt_s;
            dmem_en_r    <= dmem_en_nxt_s;
            dmem_we_r    <= dmem_we_nxt_s;
            run_r        <= run_nxt_s;
            step_r       <= step_nxt_s;
            pcrst_r      <= pcrst_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_data_r  <= resp_data_nxt_s;
            if (accept_s) begin
                addr_r  <= host.cmd_addr;
                wdata_r <= host.cmd_wdata;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
            // Clear wins over a same-cycle increment.
            if (cnt_clr_s) begin
                adv_count_r <= '0;
            end else if (cnt_inc_s) begin
                adv_count_r <= adv_count_r + CNT_W'(1);
            end else begin
                adv_count_r <= adv_count_r;
            end
        end
    end

    assign host.cmd_ready  = cmd_ready_s;
    assign host.resp_valid = resp_valid_r;
    assign host.resp_err   = resp_err_r;
    assign host.resp_data  = resp_data_r;

    assign imem_prog_we    = imem_we_r;
    assign imem_prog_addr  = addr_r;
    assign imem_prog_wdata = wdata_r[31:0];
    assign dmem_prog_en    = dmem_en_r;
    assign dmem_prog_we    = dmem_we_r;
    assign dmem_prog_addr  = addr_r[7:0];
    assign dmem_prog_wdata = wdata_r;
    assign run             = run_r;
    assign step            = step_r;
    assign pc_reset_pulse  = pcrst_r;
    assign adv_count       = adv_count_r;

endmodule

// File: tb/tb_mem_prog_ctrl.sv
// tb_mem_prog_ctrl
// Directed bench for mem_prog_ctrl. Stimulus pushes each expected response into
// a queue; a monitor pops and compares whenever resp_valid is seen. Strobe and
// control timing is checked cycle by cycle from the stimulus process. A small
// D-mem port B model gives one-cycle registered read latency.
module tb_mem_prog_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_prog_we;
    logic [8:0]  imem_prog_addr;
    logic [31:0] imem_prog_wdata;
    logic        dmem_prog_en;
    logic        dmem_prog_we;
    logic [7:0]  dmem_prog_addr;
    logic [63:0] dmem_prog_wdata;
    logic [63:0] dmem_prog_rdata = 64'd0;
    logic        run;
    logic        step;
    logic        pc_reset_pulse;
    logic [31:0] adv_count;

    mem_prog_ctrl_if hif ();

    mem_prog_ctrl #(.CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .host            (hif),
        .imem_prog_we    (imem_prog_we),
        .imem_prog_addr  (imem_prog_addr),
        .imem_prog_wdata (imem_prog_wdata),
        .dmem_prog_en    (dmem_prog_en),
        .dmem_prog_we    (dmem_prog_we),
        .dmem_prog_addr  (dmem_prog_addr),
        .dmem_prog_wdata (dmem_prog_wdata),
        .dmem_prog_rdata (dmem_prog_rdata),
        .run             (run),
        .step            (step),
        .pc_reset_pulse  (pc_reset_pulse),
        .adv_count       (adv_count)
    );

    always #5 clk = ~clk;

    // D-mem port B: read-first, one-cycle registered read data.
    logic [63:0] dmem [0:255];
    always @(posedge clk) begin
        if (dmem_prog_en) begin
            if (dmem_prog_we) dmem[dmem_prog_addr] <= dmem_prog_wdata;
            dmem_prog_rdata <= dmem[dmem_prog_addr];
        end
    end

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    localparam logic [63:0] D_PAT = 64'h0123456789ABCDEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {55'd0, imem_prog_we, dmem_prog_en, dmem_prog_we, run, step,
                            pc_reset_pulse, hif.resp_valid, hif.resp_err, hif.cmd_ready}, 64'd0);
        chk({tag, "_rdata"}, hif.resp_data, 64'd0);
        chk({tag, "_count"}, {32'd0, adv_count}, 64'd0);
        chk({tag, "_addr"}, {47'd0, imem_prog_addr, dmem_prog_addr}, 64'd0);
        chk({tag, "_wdata"}, dmem_prog_wdata | {32'd0, imem_prog_wdata}, 64'd0);
    endtask

    // Wait (bounded) for ready at a falling edge, present the command, return
    // just after the acceptance edge with cmd_valid dropped.
    task automatic send(input logic [2:0] op, input logic [8:0] addr, input logic [63:0] wdata,
                        input bit push, input logic err, input logic [63:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!hif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!hif.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 50 cycles (op %0d)", op);
        end
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_addr  = addr;
        hif.cmd_wdata = wdata;
        if (push) exp_q.push_back({err, data});
        @(posedge clk);
        #1;
        hif.cmd_valid = 1'b0;
    endtask

    // Monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!reset && hif.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL resp_unexpected: got err=%0b data=0x%0h expected no response",
                         hif.resp_err, hif.resp_data);
            end else begin
                e = exp_q.pop_front();
                chk("resp_err", {63'd0, hif.resp_err}, {63'd0, e.err});
                chk("resp_data", hif.resp_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected completion within 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 3'd0;
        hif.cmd_addr  = 9'd0;
        hif.cmd_wdata = 64'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {63'd0, hif.cmd_ready}, 64'd1);

        // IMEM_WR 0x1A5 / 0xC0A00000
        send(3'd1, 9'h1A5, 64'h00000000C0A00000, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("imem_we_c1", {63'd0, imem_prog_we}, 64'd1);
        chk("imem_addr_c1", {55'd0, imem_prog_addr}, 64'h1A5);
        chk("imem_wdata_c1", {32'd0, imem_prog_wdata}, 64'hC0A00000);
        chk("imem_respv_c1", {63'd0, hif.resp_valid}, 64'd0);
        @(negedge clk);
        chk("imem_respv_c2", {63'd0, hif.resp_valid}, 64'd1);
        chk("imem_we_c2", {63'd0, imem_prog_we}, 64'd0);
        chk("imem_ready_c2", {63'd0, hif.cmd_ready}, 64'd0);
        @(negedge clk);
        chk("imem_ready_c3", {63'd0, hif.cmd_ready}, 64'd1);

        // DMEM_WR 0x10 then read it back
        send(3'd2, 9'h010, D_PAT, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("dwr_en_c1", {62'd0, dmem_prog_en, dmem_prog_we}, 64'd3);
        chk("dwr_addr_c1", {56'd0, dmem_prog_addr}, 64'h10);
        chk("dwr_wdata_c1", dmem_prog_wdata, D_PAT);
        send(3'd3, 9'h010, 64'd0, 1'b1, 1'b0, D_PAT);
        @(negedge clk);
        chk("drd_en_c1", {62'd0, dmem_prog_en, dmem_prog_we}, 64'd2);
        @(negedge clk);
        chk("drd_en_c2", {63'd0, dmem_prog_en}, 64'd0);
        chk("drd_respv_c2", {63'd0, hif.resp_valid}, 64'd0);
        @(negedge clk);
        chk("drd_respv_c3", {63'd0, hif.resp_valid}, 64'd1);

        // DMEM_RD with addr[8] set is rejected at once
        send(3'd3, 9'h100, 64'd0, 1'b1, 1'b1, 64'd0);
        @(negedge clk);
        chk("drd_bad_respv_c1", {63'd0, hif.resp_valid}, 64'd1);
        chk("drd_bad_en_c1", {63'd0, dmem_prog_en}, 64'd0);
        @(negedge clk);
        chk("drd_bad_en_c2", {63'd0, dmem_prog_en}, 64'd0);

        // STEP x3 with cmd_valid held: highs in cycles 1, 5, 9
        @(negedge clk);
        begin
            int n;
            n = 0;
            while (!hif.cmd_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("step_ready", {63'd0, hif.cmd_ready}, 64'd1);
        end
        repeat (3) exp_q.push_back({1'b0, 64'd0});
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = 3'd6;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("step_c%0d", c), {63'd0, step}, (c % 4 == 1) ? 64'd1 : 64'd0);
            if (c == 9) hif.cmd_valid = 1'b0;
        end
        chk("step_count", {32'd0, adv_count}, 64'd3);

        // PC_RESET to clear the count, RUN, rejected IMEM_WR, HALT at edge 10
        send(3'd7, 9'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("pcrst_pulse", {63'd0, pc_reset_pulse}, 64'd1);
        chk("pcrst_count", {32'd0, adv_count}, 64'd0);
        send(3'd4, 9'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("run_c1", {63'd0, run}, 64'd1);
        send(3'd1, 9'h0AA, 64'h55, 1'b1, 1'b1, 64'd0);
        @(negedge clk);
        chk("run_imem_we", {63'd0, imem_prog_we}, 64'd0);
        chk("run_rej_respv", {63'd0, hif.resp_valid}, 64'd1);
        repeat (6) @(negedge clk);
        send(3'd5, 9'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("halt_run", {63'd0, run}, 64'd0);
        chk("halt_count", {32'd0, adv_count}, 64'd10);

        // PC_RESET while running
        send(3'd4, 9'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("run2_c1", {63'd0, run}, 64'd1);
        send(3'd7, 9'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("pcrst2_pulse_c1", {63'd0, pc_reset_pulse}, 64'd1);
        chk("pcrst2_run_c1", {63'd0, run}, 64'd0);
        chk("pcrst2_count_c1", {32'd0, adv_count}, 64'd0);
        @(negedge clk);
        chk("pcrst2_pulse_c2", {63'd0, pc_reset_pulse}, 64'd0);
        chk("pcrst2_respv_c2", {63'd0, hif.resp_valid}, 64'd1);

        // Reset asserted while in RD_CAP aborts the read with no response
        send(3'd3, 9'h010, 64'd0, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        chk("abort_en_c1", {63'd0, dmem_prog_en}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("abort_c3");
        @(negedge clk);
        chk_zero("abort_c4");
        reset = 1'b0;

        // First command after reset is accepted normally
        send(3'd1, 9'h005, 64'h1234, 1'b1, 1'b0, 64'd0);
        @(negedge clk);
        chk("post_rst_we", {63'd0, imem_prog_we}, 64'd1);
        chk("post_rst_addr", {55'd0, imem_prog_addr}, 64'h005);
        chk("post_rst_wdata", {32'd0, imem_prog_wdata}, 64'h1234);

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
